// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_pkg : shared state encoding and BCD digit arithmetic for the counter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;
  localparam int NDIGITS   = 3;
  localparam int BCD_W     = DIGIT_W * NDIGITS;

  localparam logic [BCD_W-1:0] BCD_ZERO = '0;
  localparam logic [BCD_W-1:0] BCD_MAX  = {NDIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [DIGIT_W-1:0] d;
    r = v;
    for (int i = 0; i < NDIGITS; i++) begin
      d = v[i*DIGIT_W +: DIGIT_W];
      if (d > DIGIT_W'(DIGIT_MAX)) r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(DIGIT_MAX);
    end
    return r;
  endfunction

  // Ripple carry/borrow across digits; the terminal values wrap naturally.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] v, input logic up);
    logic [BCD_W-1:0] r;
    logic [DIGIT_W-1:0] d;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      d = v[i*DIGIT_W +: DIGIT_W];
      if (c) begin
        if (up) begin
          if (d == DIGIT_W'(DIGIT_MAX)) d = '0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == '0) d = DIGIT_W'(DIGIT_MAX);
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[i*DIGIT_W +: DIGIT_W] = d;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_count_ctrl_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tick_gen : count-rate prescaler with enable, sync clear and hold         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tick_gen #(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic step_o
);

  localparam logic [PW-1:0] C_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign step_o = en_i && (cnt_q == C_LAST);

  // Disabled means hold, so a pause keeps the partial interval.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (step_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/bcd_count_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_count_ctrl : run/pause/halt sequencer for the 3-digit BCD counter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic              Clk50,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Clear,
  input  logic              Load,
  input  logic [BCD_W-1:0]  LoadVal,
  input  logic              Up,
  input  logic              Wrap,
  output logic [BCD_W-1:0]  Bcd,
  output logic              Tick,
  output logic              Rolled,
  output logic              Done,
  output logic              Running
);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             tick_q, tick_d;
  logic             rolled_q, rolled_d;
  logic             done_q, done_d;
  logic             running_q, running_d;

  logic load_acc_w, stop_acc_w, start_acc_w;
  logic pre_en_w, pre_clr_w, step_w, terminal_w;

  // Priority decode: Load is ignored in RUN so Stop/Start fall through.
  assign load_acc_w  = !Clear && Load && (state_q != RUN);
  assign stop_acc_w  = !Clear && !load_acc_w && Stop && (state_q == RUN);
  assign start_acc_w = !Clear && !load_acc_w && !stop_acc_w && Start &&
                       ((state_q == IDLE) || (state_q == PAUSE));

  assign pre_en_w   = (state_q == RUN) && !Clear && !Stop;
  assign pre_clr_w  = Clear || load_acc_w;
  assign terminal_w = Up ? (bcd_q == BCD_MAX) : (bcd_q == BCD_ZERO);

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PW       (PW)
  ) u_tick_gen (
    .clk_i  (Clk50),
    .rst_i  (Reset),
    .clr_i  (pre_clr_w),
    .en_i   (pre_en_w),
    .step_o (step_w)
  );

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state_q   <= IDLE;
      bcd_q     <= BCD_ZERO;
      tick_q    <= 1'b0;
      rolled_q  <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      tick_q    <= tick_d;
      rolled_q  <= rolled_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    if (Clear) begin
      state_d = IDLE;
      bcd_d   = BCD_ZERO;
    end else if (load_acc_w) begin
      state_d = IDLE;
      bcd_d   = bcd_clamp(LoadVal);
    end else if (stop_acc_w) begin
      state_d = PAUSE;
    end else if (start_acc_w) begin
      state_d = RUN;
    end else if (step_w) begin
      if (terminal_w && !Wrap) state_d = HALT;
      else                     bcd_d   = bcd_step(bcd_q, Up);
    end
  end

  always_comb begin
    tick_d    = step_w;
    rolled_d  = step_w && terminal_w && Wrap;
    done_d    = step_w && terminal_w && !Wrap;
    running_d = (state_d == RUN);
  end

  assign Bcd     = bcd_q;
  assign Tick    = tick_q;
  assign Rolled  = rolled_q;
  assign Done    = done_q;
  assign Running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_count_ctrl : directed self-checking bench, TICK_DIV = 4           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bcd_count_ctrl;

  logic        Clk50 = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Stop  = 1'b0;
  logic        Clear = 1'b0;
  logic        Load  = 1'b0;
  logic [11:0] LoadVal = 12'h000;
  logic        Up    = 1'b1;
  logic        Wrap  = 1'b1;
  logic [11:0] Bcd;
  logic        Tick, Rolled, Done, Running;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_count_ctrl #(.TICK_DIV(4), .PW(3)) dut (
    .Clk50   (Clk50),
    .Reset   (Reset),
    .Start   (Start),
    .Stop    (Stop),
    .Clear   (Clear),
    .Load    (Load),
    .LoadVal (LoadVal),
    .Up      (Up),
    .Wrap    (Wrap),
    .Bcd     (Bcd),
    .Tick    (Tick),
    .Rolled  (Rolled),
    .Done    (Done),
    .Running (Running)
  );

  always #5 Clk50 = ~Clk50;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk50);
  endtask

  task automatic do_load(input logic [11:0] v);
    LoadVal = v; Load = 1'b1; cyc(1); Load = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1; cyc(1); Start = 1'b0;
  endtask

  task automatic do_clear();
    Clear = 1'b1; cyc(1); Clear = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; cyc(2); Reset = 1'b0;
    n_checks++;
    if ({Bcd, Tick, Rolled, Done, Running} !== 16'h0000)
      $display("FAIL reset: got bcd=%h t/r/d/run=%b%b%b%b want 000 0000", Bcd, Tick, Rolled, Done, Running);
    else n_pass++;
  endtask

  task automatic test_count();
    Up = 1'b1; Wrap = 1'b1;
    do_start();
    n_checks++;
    if (Running !== 1'b1) $display("FAIL start_running: got %b want 1", Running);
    else n_pass++;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      n_checks++;
      if (Tick !== ((k % 4) == 0) || Bcd !== 12'(k / 4))
        $display("FAIL count k=%0d: got tick=%b bcd=%h want tick=%b bcd=%h",
                 k, Tick, Bcd, ((k % 4) == 0), 12'(k / 4));
      else n_pass++;
    end
    do_clear();
  endtask

  task automatic test_load_clamp();
    do_load(12'h098);
    n_checks++;
    if (Bcd !== 12'h098 || Running !== 1'b0) $display("FAIL load: got %h run=%b want 098 run=0", Bcd, Running);
    else n_pass++;
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h099 || Tick !== 1'b1) $display("FAIL step099: got %h tick=%b want 099 1", Bcd, Tick);
    else n_pass++;
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h100) $display("FAIL carry100: got %h want 100", Bcd);
    else n_pass++;
    // Load is ignored in RUN
    do_load(12'h555);
    n_checks++;
    if (Bcd !== 12'h100 || Running !== 1'b1) $display("FAIL load_in_run: got %h run=%b want 100 1", Bcd, Running);
    else n_pass++;
    Stop = 1'b1; cyc(1); Stop = 1'b0;
    do_load(12'h0F9);
    n_checks++;
    if (Bcd !== 12'h099 || Running !== 1'b0) $display("FAIL clamp: got %h run=%b want 099 0", Bcd, Running);
    else n_pass++;
  endtask

  task automatic test_wrap();
    Up = 1'b1; Wrap = 1'b1;
    do_load(12'h999);
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h000 || Rolled !== 1'b1 || Tick !== 1'b1 || Running !== 1'b1 || Done !== 1'b0)
      $display("FAIL wrap_up: got %h r=%b t=%b run=%b d=%b want 000 1 1 1 0", Bcd, Rolled, Tick, Running, Done);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (Rolled !== 1'b0 || Tick !== 1'b0) $display("FAIL wrap_pulse_len: got r=%b t=%b want 0 0", Rolled, Tick);
    else n_pass++;
    do_clear();
    Up = 1'b0;
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h999 || Rolled !== 1'b1) $display("FAIL wrap_down: got %h r=%b want 999 1", Bcd, Rolled);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_halt();
    Up = 1'b1; Wrap = 1'b0;
    do_load(12'h999);
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h999 || Done !== 1'b1 || Tick !== 1'b1 || Running !== 1'b0 || Rolled !== 1'b0)
      $display("FAIL halt_up: got %h d=%b t=%b run=%b r=%b want 999 1 1 0 0", Bcd, Done, Tick, Running, Rolled);
    else n_pass++;
    do_start();
    cyc(6);
    n_checks++;
    if (Bcd !== 12'h999 || Running !== 1'b0 || Done !== 1'b0 || Tick !== 1'b0)
      $display("FAIL halt_start_ignored: got %h run=%b d=%b t=%b want 999 0 0 0", Bcd, Running, Done, Tick);
    else n_pass++;
    do_clear();
    n_checks++;
    if (Bcd !== 12'h000 || Running !== 1'b0) $display("FAIL halt_clear: got %h run=%b want 000 0", Bcd, Running);
    else n_pass++;
    Up = 1'b0;
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h000 || Done !== 1'b1 || Running !== 1'b0) $display("FAIL halt_down: got %h d=%b run=%b want 000 1 0", Bcd, Done, Running);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_down_pause();
    Up = 1'b0; Wrap = 1'b1;
    do_load(12'h100);
    do_start();
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h099) $display("FAIL borrow099: got %h want 099", Bcd);
    else n_pass++;
    cyc(4);
    n_checks++;
    if (Bcd !== 12'h098) $display("FAIL down098: got %h want 098", Bcd);
    else n_pass++;
    cyc(3);
    Stop = 1'b1; cyc(1); Stop = 1'b0;
    n_checks++;
    if (Tick !== 1'b0 || Bcd !== 12'h098 || Running !== 1'b0)
      $display("FAIL stop_on_step: got t=%b bcd=%h run=%b want 0 098 0", Tick, Bcd, Running);
    else n_pass++;
    cyc(3);
    do_start();
    n_checks++;
    if (Running !== 1'b1 || Bcd !== 12'h098) $display("FAIL resume: got run=%b bcd=%h want 1 098", Running, Bcd);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (Tick !== 1'b1 || Bcd !== 12'h097) $display("FAIL resume_step: got t=%b bcd=%h want 1 097", Tick, Bcd);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_back_to_back();
    Up = 1'b1; Wrap = 1'b1;
    do_load(12'h057);
    do_start();
    cyc(3);
    Reset = 1'b1; cyc(1);
    n_checks++;
    if ({Bcd, Tick, Rolled, Done, Running} !== 16'h0000)
      $display("FAIL reset_mid_run: got bcd=%h t/r/d/run=%b%b%b%b want 000 0000", Bcd, Tick, Rolled, Done, Running);
    else n_pass++;
    Reset = 1'b0;
    cyc(6);
    n_checks++;
    if (Bcd !== 12'h000 || Tick !== 1'b0) $display("FAIL reset_idle: got %h t=%b want 000 0", Bcd, Tick);
    else n_pass++;
    do_load(12'h123);
    Clear = 1'b1; LoadVal = 12'h456; Load = 1'b1; cyc(1);
    Clear = 1'b0; Load = 1'b0;
    n_checks++;
    if (Bcd !== 12'h000) $display("FAIL clear_over_load: got %h want 000", Bcd);
    else n_pass++;
    // Clear on a step edge suppresses the step
    do_load(12'h999);
    do_start();
    cyc(3);
    Clear = 1'b1; cyc(1); Clear = 1'b0;
    n_checks++;
    if (Bcd !== 12'h000 || Tick !== 1'b0 || Rolled !== 1'b0 || Running !== 1'b0)
      $display("FAIL clear_on_step: got %h t=%b r=%b run=%b want 000 0 0 0", Bcd, Tick, Rolled, Running);
    else n_pass++;
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_count();
    test_load_clamp();
    test_wrap();
    test_halt();
    test_down_pause();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
